// File: rtl/branch_predict_ctrl.sv
// Branch predictor/resolver: 2-bit saturating BHT lookup for fetch, branch/jump
// resolution with registered redirect, and saturating branch/mispredict statistics.
module branch_predict_ctrl #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  pc_if,
  output logic             pred_taken_if,
  input  logic             res_valid,
  input  logic [3:0]       pcctrl,
  input  logic [1:0]       comp_out,
  input  logic [PC_W-1:0]  pc_id,
  input  logic [PC_W-1:0]  target,
  input  logic             pred_taken_id,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int BHT_N = 2 ** IDX_W;

  logic [1:0]       bht_q [BHT_N];
  logic             redirect_q, redirect_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic             ev_s;
  logic             actual_s;
  logic             bht_we_s;
  logic [IDX_W-1:0] upd_idx_s;
  logic [1:0]       bht_wdata_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [1:0] bht_train(input logic [1:0] v, input logic taken);
    if (taken) return (v == 2'd3) ? 2'd3 : v + 2'd1;
    else       return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign pred_taken_if = bht_q[pc_if[IDX_W+1:2]][1];
  assign redirect      = redirect_q;
  assign redirect_pc   = redirect_pc_q;
  assign branch_cnt    = branch_cnt_q;
  assign mispred_cnt   = mispred_cnt_q;

  // Resolution: outcome, BHT training, redirect and statistics next-state.
  always_comb begin
    ev_s          = res_valid & ~redirect_q;
    upd_idx_s     = pc_id[IDX_W+1:2];
    actual_s      = 1'b0;
    bht_we_s      = 1'b0;
    bht_wdata_s   = bht_q[upd_idx_s];
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    case (pcctrl[1:0])
      2'b00:   actual_s = (comp_out == 2'b00);
      2'b01:   actual_s = (comp_out != 2'b00);
      2'b10:   actual_s = (comp_out == 2'b01);
      2'b11:   actual_s = (comp_out != 2'b01);
      default: actual_s = 1'b0;
    endcase

    if (ev_s && pcctrl[3]) begin
      bht_we_s     = 1'b1;
      bht_wdata_s  = bht_train(bht_q[upd_idx_s], actual_s);
      branch_cnt_d = sat_inc(branch_cnt_q);
      if (actual_s != pred_taken_id) begin
        mispred_cnt_d = sat_inc(mispred_cnt_q);
        redirect_d    = 1'b1;
        redirect_pc_d = actual_s ? target : pc_id + PC_W'(3'd4);
      end else begin
        redirect_d = 1'b0;
      end
    end else if (ev_s && pcctrl[2]) begin
      mispred_cnt_d = sat_inc(mispred_cnt_q);
      redirect_d    = 1'b1;
      redirect_pc_d = target;
    end else begin
      redirect_d = 1'b0;
    end
  end

  // State registers; reset reinitialises every BHT entry to weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (bht_we_s) bht_q[upd_idx_s] <= bht_wdata_s;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule
